// File: rtl/block_reduce_pkg.sv
// Shared encodings for the block reduction engine: reduction modes and FSM states.
package block_reduce_pkg;

    typedef logic [1:0] mode_t;
    typedef logic [1:0] state_t;

    localparam mode_t MODE_SUM = 2'b00;
    localparam mode_t MODE_MAX = 2'b01;
    localparam mode_t MODE_MIN = 2'b10;
    localparam mode_t MODE_XOR = 2'b11;

    // A finished run parks in StIdle with Ready held high.
    localparam state_t StIdle  = 2'd0;
    localparam state_t StRead  = 2'd1;
    localparam state_t StDrain = 2'd2;
    localparam state_t StWrite = 2'd3;

endpackage

// File: rtl/reduce_alu.sv
// Combinational reduction step: result = op(acc, din); carry only meaningful for sum.
module reduce_alu
    import block_reduce_pkg::*;
#(
    parameter int unsigned DATA_W = 16
) (
    input  logic [DATA_W-1:0] acc_i,
    input  logic [DATA_W-1:0] din_i,
    input  mode_t             mode_i,
    output logic [DATA_W-1:0] result_o,
    output logic              carry_o
);

    logic [DATA_W:0] sum;

    assign sum = {1'b0, acc_i} + {1'b0, din_i};

    always_comb begin
        result_o = sum[DATA_W-1:0];
        carry_o  = 1'b0;
        case (mode_i)
            MODE_SUM: begin
                result_o = sum[DATA_W-1:0];
                carry_o  = sum[DATA_W];
            end
            MODE_MAX: result_o = (din_i > acc_i) ? din_i : acc_i;
            MODE_MIN: result_o = (din_i < acc_i) ? din_i : acc_i;
            default:  result_o = acc_i ^ din_i;
        endcase
    end

endmodule

// File: rtl/block_reduce_engine.sv
// Walks NUM_BLOCKS blocks in SRAM, reduces the first BLOCK_LEN-1 words of each block
// and writes the result into the block's last word. All outputs are registered.
module block_reduce_engine
    import block_reduce_pkg::*;
#(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned ADDR_W     = 5,
    parameter int unsigned BLOCK_LEN  = 8,
    parameter int unsigned NUM_BLOCKS = 4,
    parameter int unsigned BASE_ADDR  = 0
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Start,
    input  logic [1:0]        Mode,
    output logic              Busy,
    output logic              Ready,
    output logic              Overflow,
    output logic [ADDR_W-1:0] Address,
    output logic              ReadEnable,
    output logic              WriteEnable,
    output logic [DATA_W-1:0] DataIN,
    input  logic [DATA_W-1:0] DataOut
);

    localparam int unsigned WidxW = (BLOCK_LEN > 2) ? $clog2(BLOCK_LEN - 1) : 1;
    localparam int unsigned BlkW  = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;

    state_t            state_q, state_d;
    mode_t             mode_q, mode_d;
    logic [BlkW-1:0]   blk_q, blk_d;
    logic [WidxW-1:0]  widx_q, widx_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              re_q, re_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] din_q, din_d;
    logic              busy_q, busy_d;
    logic              ready_q, ready_d;
    logic              ovf_q, ovf_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic              rvalid_q, rvalid_d;
    logic              rfirst_q, rfirst_d;

    logic [DATA_W-1:0] alu_result;
    logic              alu_carry;
    logic [DATA_W-1:0] acc_next;

    reduce_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .acc_i    (acc_q),
        .din_i    (DataOut),
        .mode_i   (mode_q),
        .result_o (alu_result),
        .carry_o  (alu_carry)
    );

    // The first word of a block replaces the accumulator rather than combining with it.
    assign acc_next = rfirst_q ? DataOut : alu_result;

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        blk_d    = blk_q;
        widx_d   = widx_q;
        base_d   = base_q;
        addr_d   = addr_q;
        re_d     = re_q;
        we_d     = 1'b0;
        din_d    = din_q;
        busy_d   = busy_q;
        ready_d  = ready_q;
        ovf_d    = ovf_q;
        acc_d    = acc_q;
        rvalid_d = re_q;
        rfirst_d = re_q && (widx_q == '0);

        if (rvalid_q) begin
            acc_d = acc_next;
            if (!rfirst_q && (mode_q == MODE_SUM) && alu_carry) begin
                ovf_d = 1'b1;
            end
        end

        case (state_q)
            StIdle: begin
                if (Start) begin
                    mode_d  = Mode;
                    ovf_d   = 1'b0;
                    ready_d = 1'b0;
                    busy_d  = 1'b1;
                    blk_d   = '0;
                    widx_d  = '0;
                    base_d  = ADDR_W'(BASE_ADDR);
                    addr_d  = ADDR_W'(BASE_ADDR);
                    re_d    = 1'b1;
                    state_d = StRead;
                end
            end
            StRead: begin
                if (widx_q == WidxW'(BLOCK_LEN - 2)) begin
                    re_d    = 1'b0;
                    state_d = StDrain;
                end else begin
                    widx_d = widx_q + 1'b1;
                    addr_d = addr_q + 1'b1;
                end
            end
            StDrain: begin
                we_d    = 1'b1;
                addr_d  = base_q + ADDR_W'(BLOCK_LEN - 1);
                din_d   = acc_next;
                state_d = StWrite;
            end
            StWrite: begin
                if (blk_q == BlkW'(NUM_BLOCKS - 1)) begin
                    busy_d  = 1'b0;
                    ready_d = 1'b1;
                    state_d = StIdle;
                end else begin
                    blk_d   = blk_q + 1'b1;
                    base_d  = base_q + ADDR_W'(BLOCK_LEN);
                    addr_d  = base_q + ADDR_W'(BLOCK_LEN);
                    widx_d  = '0;
                    re_d    = 1'b1;
                    state_d = StRead;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q  <= StIdle;
            mode_q   <= MODE_SUM;
            blk_q    <= '0;
            widx_q   <= '0;
            base_q   <= '0;
            addr_q   <= '0;
            re_q     <= 1'b0;
            we_q     <= 1'b0;
            din_q    <= '0;
            busy_q   <= 1'b0;
            ready_q  <= 1'b0;
            ovf_q    <= 1'b0;
            acc_q    <= '0;
            rvalid_q <= 1'b0;
            rfirst_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            blk_q    <= blk_d;
            widx_q   <= widx_d;
            base_q   <= base_d;
            addr_q   <= addr_d;
            re_q     <= re_d;
            we_q     <= we_d;
            din_q    <= din_d;
            busy_q   <= busy_d;
            ready_q  <= ready_d;
            ovf_q    <= ovf_d;
            acc_q    <= acc_d;
            rvalid_q <= rvalid_d;
            rfirst_q <= rfirst_d;
        end
    end

    assign Busy        = busy_q;
    assign Ready       = ready_q;
    assign Overflow    = ovf_q;
    assign Address     = addr_q;
    assign ReadEnable  = re_q;
    assign WriteEnable = we_q;
    assign DataIN      = din_q;

endmodule

// File: tb/tb_block_reduce_engine.sv
// Directed bench: default engine plus a BLOCK_LEN=2 / NUM_BLOCKS=16 instance, each on a
// small synchronous SRAM model.
module tb_block_reduce_engine;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  mode  = 2'b00;
    logic        busy, ready, overflow, read_enable, write_enable;
    logic [4:0]  address;
    logic [15:0] data_in;
    logic [15:0] rdata = 16'h0;
    logic [15:0] mem [32];

    logic        b_start = 1'b0;
    logic        b_busy, b_ready, b_overflow, b_read_enable, b_write_enable;
    logic [4:0]  b_address;
    logic [15:0] b_data_in;
    logic [15:0] b_rdata = 16'h0;
    logic [15:0] b_mem [32];

    logic        ld_en   = 1'b0;
    logic        ld_sel  = 1'b0;
    logic [4:0]  ld_addr = 5'd0;
    logic [15:0] ld_data = 16'h0;

    int vectors = 0;
    int miscompares = 0;

    int          ready_cyc;
    int          overlaps;
    logic        ovf_at_ready;
    logic        busy_at_ready;
    int          wr_cyc  [$];
    logic [4:0]  wr_addr [$];
    logic [15:0] wr_data [$];
    logic [15:0] pat [7];

    always #5 clock = ~clock;

    block_reduce_engine #(
        .DATA_W     (16),
        .ADDR_W     (5),
        .BLOCK_LEN  (8),
        .NUM_BLOCKS (4),
        .BASE_ADDR  (0)
    ) dut (
        .Clock       (clock),
        .Reset       (reset),
        .Start       (start),
        .Mode        (mode),
        .Busy        (busy),
        .Ready       (ready),
        .Overflow    (overflow),
        .Address     (address),
        .ReadEnable  (read_enable),
        .WriteEnable (write_enable),
        .DataIN      (data_in),
        .DataOut     (rdata)
    );

    block_reduce_engine #(
        .DATA_W     (16),
        .ADDR_W     (5),
        .BLOCK_LEN  (2),
        .NUM_BLOCKS (16),
        .BASE_ADDR  (0)
    ) dut_b (
        .Clock       (clock),
        .Reset       (reset),
        .Start       (b_start),
        .Mode        (2'b00),
        .Busy        (b_busy),
        .Ready       (b_ready),
        .Overflow    (b_overflow),
        .Address     (b_address),
        .ReadEnable  (b_read_enable),
        .WriteEnable (b_write_enable),
        .DataIN      (b_data_in),
        .DataOut     (b_rdata)
    );

    always @(posedge clock) begin
        if (ld_en && !ld_sel) mem[ld_addr] <= ld_data;
        else if (write_enable) mem[address] <= data_in;
        if (read_enable) rdata <= mem[address];
        if (ld_en && ld_sel) b_mem[ld_addr] <= ld_data;
        else if (b_write_enable) b_mem[b_address] <= b_data_in;
        if (b_read_enable) b_rdata <= b_mem[b_address];
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Called at a negedge; the write lands on the next posedge.
    task automatic load_word(input bit sel, input int addr, input logic [15:0] data);
        ld_en   = 1'b1;
        ld_sel  = sel;
        ld_addr = 5'(addr);
        ld_data = data;
        @(negedge clock);
        ld_en = 1'b0;
    endtask

    task automatic load_block(input int k);
        for (int i = 0; i < 7; i++) load_word(1'b0, k * 8 + i, pat[i]);
    endtask

    // Start is raised mid-cycle 0; cycle c is sampled at its negedge.
    task automatic run(input logic [1:0] m, input bit disturb, input int abort_at);
        wr_cyc.delete();
        wr_addr.delete();
        wr_data.delete();
        ready_cyc = -1;
        overlaps  = 0;
        mode  = m;
        start = 1'b1;
        for (int c = 1; c <= 100; c++) begin
            @(posedge clock);
            #1;
            start = 1'b0;
            if (disturb && c >= 5 && c <= 20) begin
                start = c[0];
                mode  = c[1:0];
            end
            if (c == abort_at) begin
                reset = 1'b1;
                break;
            end
            @(negedge clock);
            if (read_enable && write_enable) overlaps++;
            if (write_enable) begin
                wr_cyc.push_back(c);
                wr_addr.push_back(address);
                wr_data.push_back(data_in);
            end
            if (ready) begin
                ready_cyc     = c;
                ovf_at_ready  = overflow;
                busy_at_ready = busy;
                break;
            end
        end
    endtask

    task automatic check_writes(input string tag, input logic [15:0] d0, input logic [15:0] d1,
                                input logic [15:0] d2, input logic [15:0] d3);
        logic [15:0] exp_d [4];
        exp_d = '{d0, d1, d2, d3};
        check({tag, "_wr_count"}, wr_cyc.size(), 4);
        for (int i = 0; i < 4 && i < wr_cyc.size(); i++) begin
            check({tag, "_wr_cycle"}, wr_cyc[i], (i + 1) * 9);
            check({tag, "_wr_addr"}, {27'd0, wr_addr[i]}, i * 8 + 7);
            check({tag, "_wr_data"}, {16'd0, wr_data[i]}, {16'd0, exp_d[i]});
        end
        check({tag, "_ready_cycle"}, ready_cyc, 37);
        check({tag, "_busy_at_ready"}, {31'd0, busy_at_ready}, 0);
        check({tag, "_overlap"}, overlaps, 0);
    endtask

    initial begin
        // Reset state
        #2 reset = 1'b1;
        @(negedge clock);
        @(negedge clock);
        check("reset_outputs",
              {6'd0, busy, ready, overflow, address, read_enable, write_enable, data_in}, 0);
        reset = 1'b0;

        for (int a = 0; a < 32; a++) begin
            load_word(1'b0, a, ((a % 8) == 7) ? 16'hDEAD : 16'((a % 8) + 1));
        end
        for (int j = 0; j < 16; j++) begin
            load_word(1'b1, 2 * j, 16'hA000 + 16'(j) * 16'h0101);
            load_word(1'b1, 2 * j + 1, 16'hDEAD);
        end

        // Sum of 1..7 in every block
        run(2'b00, 1'b0, 0);
        check_writes("sum", 16'h1C, 16'h1C, 16'h1C, 16'h1C);
        check("sum_ovf", {31'd0, ovf_at_ready}, 0);
        check("sum_mem7", {16'd0, mem[7]}, 32'h1C);
        check("sum_mem31", {16'd0, mem[31]}, 32'h1C);

        // Max / min / xor
        pat = '{16'h3, 16'h9, 16'h2, 16'hFFFF, 16'h0, 16'h7, 16'h1};
        load_block(0);
        run(2'b01, 1'b0, 0);
        check("max_mem7", {16'd0, mem[7]}, 32'hFFFF);
        check("max_mem15", {16'd0, mem[15]}, 32'h7);
        check("max_ovf", {31'd0, ovf_at_ready}, 0);
        run(2'b10, 1'b0, 0);
        check("min_mem7", {16'd0, mem[7]}, 32'h0);
        check("min_mem15", {16'd0, mem[15]}, 32'h1);
        pat = '{16'h1, 16'h2, 16'h4, 16'h8, 16'h10, 16'h20, 16'h40};
        load_block(0);
        run(2'b11, 1'b0, 0);
        check("xor_mem7", {16'd0, mem[7]}, 32'h7F);
        check("xor_mem15", {16'd0, mem[15]}, 32'h0);
        check("xor_ready_cycle", ready_cyc, 37);

        // Sum carry in block 1
        pat = '{16'hFFFF, 16'h2, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
        load_block(1);
        run(2'b00, 1'b0, 0);
        check("carry_mem15", {16'd0, mem[15]}, 32'h1);
        check("carry_mem7", {16'd0, mem[7]}, 32'h7F);
        check("carry_ovf", {31'd0, ovf_at_ready}, 1);
        pat = '{16'h1, 16'h2, 16'h3, 16'h4, 16'h5, 16'h6, 16'h7};
        load_block(1);
        run(2'b00, 1'b0, 0);
        check("nocarry_ovf", {31'd0, ovf_at_ready}, 0);
        check("nocarry_mem15", {16'd0, mem[15]}, 32'h1C);

        // Restart in the first Ready cycle, with Start/Mode noise during the run
        run(2'b00, 1'b1, 0);
        check_writes("noise", 16'h7F, 16'h1C, 16'h1C, 16'h1C);

        // Abort in cycle 12
        load_word(1'b0, 7, 16'hBEEF);
        load_word(1'b0, 15, 16'hBEEF);
        run(2'b00, 1'b0, 12);
        @(negedge clock);
        check("abort_outputs",
              {6'd0, busy, ready, overflow, address, read_enable, write_enable, data_in}, 0);
        @(posedge clock);
        @(negedge clock);
        check("abort_next_edge",
              {6'd0, busy, ready, overflow, address, read_enable, write_enable, data_in}, 0);
        reset = 1'b0;
        @(negedge clock);
        check("abort_mem7", {16'd0, mem[7]}, 32'h7F);
        check("abort_mem15", {16'd0, mem[15]}, 32'hBEEF);
        run(2'b00, 1'b0, 0);
        check("fresh_ready_cycle", ready_cyc, 37);
        check("fresh_mem15", {16'd0, mem[15]}, 32'h1C);

        // BLOCK_LEN=2, NUM_BLOCKS=16 copy-through
        ready_cyc = -1;
        overlaps  = 0;
        wr_cyc.delete();
        b_start = 1'b1;
        for (int c = 1; c <= 80; c++) begin
            @(posedge clock);
            #1;
            b_start = 1'b0;
            @(negedge clock);
            if (b_read_enable && b_write_enable) overlaps++;
            if (b_write_enable) wr_cyc.push_back(c);
            if (b_ready) begin
                ready_cyc = c;
                break;
            end
        end
        check("b_ready_cycle", ready_cyc, 49);
        check("b_overlap", overlaps, 0);
        check("b_wr_count", wr_cyc.size(), 16);
        check("b_ovf", {31'd0, b_overflow}, 0);
        for (int j = 0; j < 16; j++) begin
            check("b_odd_word", {16'd0, b_mem[2 * j + 1]}, {16'd0, 16'hA000 + 16'(j) * 16'h0101});
        end
        check("b_even_word", {16'd0, b_mem[30]}, 32'hAF0F);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
